// File: rtl/cv32e40p_ft_error_monitor.sv
// Fault-tolerant voter error monitor: counts corrected/uncorrectable voter events and
// raises a req/ack recovery request. Define CV32E40P_FT_FAULT_IDX_EN to build fault_idx_o.
module cv32e40p_ft_error_monitor #(
  parameter int N_VOTERS    = 8,
  parameter int CNT_W       = 16,
  parameter int CORR_THRESH = 4,
  parameter int COOL_CYC    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_VOTERS-1:0]         err_correct_i,
  input  logic [N_VOTERS-1:0]         err_detected_i,
  input  logic                        clear_i,
  input  logic                        fault_ack_i,
  output logic                        fault_req_o,
  output logic                        fault_type_o,
  output logic [$clog2(N_VOTERS)-1:0] fault_idx_o,
  output logic [CNT_W-1:0]            corr_cnt_o,
  output logic [CNT_W-1:0]            uncorr_cnt_o
);
  localparam int NW     = $clog2(N_VOTERS + 1);
  localparam int IDX_W  = $clog2(N_VOTERS);
  localparam int COOL_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, COOL} state_e;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [NW-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [COOL_W-1:0]   cool_q, cool_d;
  logic [CNT_W-1:0]    corr_cnt_q, corr_cnt_d, unc_cnt_q, unc_cnt_d;
  logic [CNT_W-1:0]    thr_acc_q, thr_acc_d, thr_base, thr_sum;
  logic                pend_unc_q, pend_unc_d, pend_set;
  logic                req_q, req_d, type_q, type_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_VOTERS-1:0] unc_v;
  logic [NW-1:0]       n_corr, n_unc;
  logic [IDX_W-1:0]    unc_idx, corr_idx, pend_idx_q;

  assign unc_v = err_detected_i & ~err_correct_i;

  always_comb begin
    n_corr = '0;
    n_unc  = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      n_corr = n_corr + NW'(err_correct_i[i]);
      n_unc  = n_unc  + NW'(unc_v[i]);
    end
  end

`ifdef CV32E40P_FT_FAULT_IDX_EN
  logic [IDX_W-1:0] pend_idx_d;

  // Scan downward so the lowest flagging voter wins.
  always_comb begin
    unc_idx  = '0;
    corr_idx = '0;
    for (int i = N_VOTERS - 1; i >= 0; i--) begin
      if (unc_v[i])         unc_idx  = IDX_W'(i);
      if (err_correct_i[i]) corr_idx = IDX_W'(i);
    end
    pend_idx_d = pend_set ? unc_idx : pend_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_idx_q <= '0;
    else        pend_idx_q <= pend_idx_d;
  end
`else
  assign unc_idx    = '0;
  assign corr_idx   = '0;
  assign pend_idx_q = '0;
`endif

  always_comb begin
    state_d    = state_q;
    cool_d     = cool_q;
    req_d      = req_q;
    type_d     = type_q;
    idx_d      = idx_q;
    pend_unc_d = pend_unc_q;
    pend_set   = 1'b0;
    corr_cnt_d = sat_add(clear_i ? '0 : corr_cnt_q, n_corr);
    unc_cnt_d  = sat_add(clear_i ? '0 : unc_cnt_q, n_unc);
    thr_base   = clear_i ? '0 : thr_acc_q;
    thr_sum    = sat_add(thr_base, n_corr);
    thr_acc_d  = thr_sum;

    case (state_q)
      IDLE: begin
        if (n_unc != '0) begin
          state_d   = REQ;
          req_d     = 1'b1;
          type_d    = 1'b1;
          idx_d     = unc_idx;
          thr_acc_d = '0;
        end else if (thr_sum >= CNT_W'(CORR_THRESH)) begin
          state_d   = REQ;
          req_d     = 1'b1;
          type_d    = 1'b0;
          idx_d     = corr_idx;
          thr_acc_d = '0;
        end
      end
      REQ: begin
        if (n_unc != '0 && !pend_unc_q) begin
          pend_set   = 1'b1;
          pend_unc_d = 1'b1;
        end
        if (fault_ack_i) begin
          state_d = COOL;
          req_d   = 1'b0;
          cool_d  = COOL_W'(COOL_CYC - 1);
        end
      end
      COOL: begin
        if (cool_q == '0) begin
          // An uncorrectable seen in the final cool cycle still counts as pending.
          if (pend_unc_q || n_unc != '0) begin
            state_d    = REQ;
            req_d      = 1'b1;
            type_d     = 1'b1;
            idx_d      = pend_unc_q ? pend_idx_q : unc_idx;
            pend_unc_d = 1'b0;
            thr_acc_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cool_d = cool_q - 1'b1;
          if (n_unc != '0 && !pend_unc_q) begin
            pend_set   = 1'b1;
            pend_unc_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cool_q     <= '0;
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
      thr_acc_q  <= '0;
      pend_unc_q <= 1'b0;
      req_q      <= 1'b0;
      type_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cool_q     <= cool_d;
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
      thr_acc_q  <= thr_acc_d;
      pend_unc_q <= pend_unc_d;
      req_q      <= req_d;
      type_q     <= type_d;
      idx_q      <= idx_d;
    end
  end

  assign fault_req_o  = req_q;
  assign fault_type_o = type_q;
  assign fault_idx_o  = idx_q;
  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = unc_cnt_q;
endmodule

// File: tb/tb_cv32e40p_ft_error_monitor.sv
// Scoreboard bench for cv32e40p_ft_error_monitor: directed scenarios plus random traffic,
// with a 4-bit-counter second instance sharing the same stimulus for saturation.
module tb_cv32e40p_ft_error_monitor;
  localparam int N = 8, THR = 4, COOL = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] corr_i = '0, det_i = '0;
  logic       clr_i = 1'b0, ack_i = 1'b0;
  logic       req, typ, req4, typ4;
  logic [2:0] idx, idx4;
  logic [15:0] ccnt, ucnt;
  logic [3:0]  ccnt4, ucnt4;

  always #5 clk = ~clk;

  cv32e40p_ft_error_monitor #(.N_VOTERS(N), .CNT_W(16), .CORR_THRESH(THR), .COOL_CYC(COOL)) dut (
    .clk(clk), .rst_n(rst_n), .err_correct_i(corr_i), .err_detected_i(det_i),
    .clear_i(clr_i), .fault_ack_i(ack_i), .fault_req_o(req), .fault_type_o(typ),
    .fault_idx_o(idx), .corr_cnt_o(ccnt), .uncorr_cnt_o(ucnt));

  cv32e40p_ft_error_monitor #(.N_VOTERS(N), .CNT_W(4), .CORR_THRESH(THR), .COOL_CYC(COOL)) dut4 (
    .clk(clk), .rst_n(rst_n), .err_correct_i(corr_i), .err_detected_i(det_i),
    .clear_i(clr_i), .fault_ack_i(ack_i), .fault_req_o(req4), .fault_type_o(typ4),
    .fault_idx_o(idx4), .corr_cnt_o(ccnt4), .uncorr_cnt_o(ucnt4));

  typedef struct packed {
    logic        req;
    logic        typ;
    logic [2:0]  idx;
    logic [15:0] corr;
    logic [15:0] unc;
    logic [3:0]  corr4;
    logic [3:0]  unc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;

  // Reference model: plain integers, mode 0 idle / 1 requesting / 2 cooling
  int m_mode, m_rem, m_corr, m_unc, m_corr4, m_unc4, m_thr, m_pidx;
  bit m_pend, m_req, m_typ;
  int m_idx;

  function automatic int lowest(input logic [7:0] v);
    int r = 0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_corr = 0; m_unc = 0; m_corr4 = 0; m_unc4 = 0;
    m_thr = 0; m_pend = 0; m_pidx = 0; m_req = 0; m_typ = 0; m_idx = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.req   = m_req;
    e.typ   = m_typ;
`ifdef CV32E40P_FT_FAULT_IDX_EN
    e.idx   = 3'(m_idx);
`else
    e.idx   = 3'd0;
`endif
    e.corr  = 16'(m_corr);
    e.unc   = 16'(m_unc);
    e.corr4 = 4'(m_corr4);
    e.unc4  = 4'(m_unc4);
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic [7:0] c, input logic [7:0] d, input bit clr, input bit ack);
    logic [7:0] u;
    int nc, nu, tb, lu;
    bit enter, etyp;
    int eidx;
    u  = d & ~c;
    nc = $countones(c);
    nu = $countones(u);
    lu = lowest(u);
    m_corr  = sat((clr ? 0 : m_corr) + nc, 65535);
    m_unc   = sat((clr ? 0 : m_unc) + nu, 65535);
    m_corr4 = sat((clr ? 0 : m_corr4) + nc, 15);
    m_unc4  = sat((clr ? 0 : m_unc4) + nu, 15);
    tb = clr ? 0 : m_thr;
    enter = 0; etyp = 0; eidx = 0;
    if (m_mode == 0) begin
      if (nu > 0) begin enter = 1; etyp = 1; eidx = lu; end
      else if (tb + nc >= THR) begin enter = 1; etyp = 0; eidx = lowest(c); end
    end else begin
      if (nu > 0 && !m_pend) begin m_pend = 1; m_pidx = lu; end
      if (m_mode == 1) begin
        if (ack) begin m_mode = 2; m_rem = COOL; m_req = 0; end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_pend) begin enter = 1; etyp = 1; eidx = m_pidx; m_pend = 0; end
          else m_mode = 0;
        end
      end
    end
    m_thr = enter ? 0 : sat(tb + nc, 65535);
    if (enter) begin m_mode = 1; m_req = 1; m_typ = etyp; m_idx = eidx; end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Each call drives one cycle of stimulus and records the post-edge expectation.
  task automatic cycle(input logic [7:0] c, input logic [7:0] d, input bit clr, input bit ack);
    @(negedge clk);
    rst_n = 1'b1; corr_i = c; det_i = d; clr_i = clr; ack_i = ack;
    model_step(c, d, clr, ack);
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic reset_cycle(input bit check_now);
    @(negedge clk);
    rst_n = 1'b0; corr_i = '0; det_i = '0; clr_i = 1'b0; ack_i = 1'b0;
    if (check_now) begin
      #1;
      chk("async_rst_req", int'(req), 0);
      chk("async_rst_type", int'(typ), 0);
      chk("async_rst_idx", int'(idx), 0);
      chk("async_rst_corr", int'(ccnt), 0);
      chk("async_rst_unc", int'(ucnt), 0);
    end
    model_reset();
    push_exp();
  endtask

  // Monitor: every post-edge output set is a transaction to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fault_req", int'(req), int'(e.req));
        chk("fault_type", int'(typ), int'(e.typ));
        chk("fault_idx", int'(idx), int'(e.idx));
        chk("corr_cnt", int'(ccnt), int'(e.corr));
        chk("uncorr_cnt", int'(ucnt), int'(e.unc));
        chk("corr_cnt_w4", int'(ccnt4), int'(e.corr4));
        chk("uncorr_cnt_w4", int'(ucnt4), int'(e.unc4));
        chk("fault_req_w4", int'(req4), int'(e.req));
      end
    end
  end

  initial begin
    logic [7:0] rc, rd;
    bit rclr, rack;
    model_reset();
    reset_cycle(1'b0);
    reset_cycle(1'b0);

    // uncorrectable on voter 5, ack, full cooldown
    cycle(8'h00, 8'h20, 0, 0);
    idle(2);
    cycle(8'h00, 8'h00, 0, 1);
    idle(COOL + 2);

    // corrected accumulation to threshold
    cycle(8'h0A, 8'h0A, 0, 0);
    idle(2);
    cycle(8'h01, 8'h01, 0, 0);
    idle(2);
    cycle(8'h44, 8'h44, 0, 0);
    cycle(8'h00, 8'h00, 0, 1);
    // uncorrectable on voter 7 and corrected traffic during cooldown
    idle(3);
    cycle(8'h00, 8'h80, 0, 0);
    cycle(8'h03, 8'h03, 0, 0);
    idle(COOL);
    cycle(8'h00, 8'h00, 0, 1);
    idle(COOL + 1);

    // same-cycle corrected + uncorrectable
    cycle(8'h01, 8'h11, 0, 0);
    cycle(8'h00, 8'h00, 0, 1);
    idle(COOL + 1);

    // saturation of the narrow counters, then clear with new events
    for (int i = 0; i < 3; i++) cycle(8'hFF, 8'hFF, 0, 0);
    cycle(8'h03, 8'h03, 1, 0);
    cycle(8'h00, 8'h00, 0, 1);
    idle(COOL + 1);

    // reset while a request is held
    cycle(8'h00, 8'h04, 0, 0);
    idle(1);
    reset_cycle(1'b1);
    idle(5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rc = '0; rd = '0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 19) == 0) rc[b] = 1'b1;
        if ($urandom_range(0, 29) == 0) rd[b] = 1'b1;
      end
      rd   = rd | (rc & 8'($urandom));
      rclr = ($urandom_range(0, 49) == 0);
      rack = ($urandom_range(0, 3) == 0);
      cycle(rc, rd, rclr, rack);
    end
    idle(3);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
